// File: rtl/psi_result_decoder.sv
// Serialises a PSI intersection bitmap into ascending element indices over valid/ready.
// Optional intersection-size counter (isect_count) is built when PSI_COUNT_EN is defined.
module psi_result_decoder #(
    parameter int UNIVERSE = 10,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bm_valid,
    output logic                bm_ready,
    input  logic [UNIVERSE-1:0] bm_data,
    output logic                idx_valid,
    input  logic                idx_ready,
    output logic [IDX_W-1:0]    idx_data,
    output logic                idx_last,
    output logic                done,
    output logic                empty,
`ifdef PSI_COUNT_EN
    output logic [IDX_W:0]      isect_count,
`endif
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // A producer holds valid and its payload stable until the transfer; ready may toggle freely.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(UNIVERSE - 1);
    localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [UNIVERSE-1:0] shadow_q, shadow_d;
    logic                idx_valid_q, idx_valid_d;
    logic [IDX_W-1:0]    idx_data_q, idx_data_d;
    logic                idx_last_q, idx_last_d;
    logic                emitted_q, emitted_d;
    logic [UNIVERSE-1:0] upper_bits;
    logic                bm_accept;
    logic                idx_hs;

    assign bm_accept  = (state_q == ST_IDLE) && bm_valid;
    assign idx_hs     = idx_valid_q && idx_ready;
    // Bits strictly above the current pointer; zero means this index is the final one.
    assign upper_bits = (shadow_q >> ptr_q) >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            shadow_q    <= '0;
            idx_valid_q <= 1'b0;
            idx_data_q  <= '0;
            idx_last_q  <= 1'b0;
            emitted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            shadow_q    <= shadow_d;
            idx_valid_q <= idx_valid_d;
            idx_data_q  <= idx_data_d;
            idx_last_q  <= idx_last_d;
            emitted_q   <= emitted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        shadow_d    = shadow_q;
        idx_valid_d = idx_valid_q;
        idx_data_d  = idx_data_q;
        idx_last_d  = idx_last_q;
        emitted_d   = emitted_q;
        case (state_q)
            ST_IDLE: begin
                if (bm_accept) begin
                    shadow_d  = bm_data;
                    ptr_d     = '0;
                    emitted_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (shadow_q[ptr_q]) begin
                    idx_data_d  = ptr_q;
                    idx_valid_d = 1'b1;
                    idx_last_d  = (upper_bits == '0);
                    emitted_d   = 1'b1;
                    state_d     = ST_EMIT;
                end else if (ptr_q == PTR_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            ST_EMIT: begin
                if (idx_hs) begin
                    idx_valid_d = 1'b0;
                    idx_last_d  = 1'b0;
                    if (idx_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bm_ready  = (state_q == ST_IDLE);
    assign idx_valid = idx_valid_q;
    assign idx_data  = idx_data_q;
    assign idx_last  = idx_last_q;
    assign done      = (state_q == ST_DONE);
    assign empty     = (state_q == ST_DONE) && !emitted_q;
    assign dbg_state = state_q;

`ifdef PSI_COUNT_EN
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

    logic [IDX_W:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bm_accept) begin
            cnt_d = '0;
        end else if (idx_hs) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign isect_count = cnt_q;
`endif

endmodule

// File: tb/tb_psi_result_decoder.sv
// Directed bench for psi_result_decoder: ordering, latency, stalls, ignored offers, reset abort.
// Counter checks are compiled in when PSI_COUNT_EN is defined.
module tb_psi_result_decoder;

    logic       clk;
    logic       rst;
    logic       bm_valid;
    logic       bm_ready;
    logic [9:0] bm_data;
    logic       idx_valid;
    logic       idx_ready;
    logic [3:0] idx_data;
    logic       idx_last;
    logic       done;
    logic       empty;
    logic [1:0] dbg_state;
`ifdef PSI_COUNT_EN
    logic [4:0] isect_count;
`endif

    psi_result_decoder #(.UNIVERSE(10), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .bm_valid(bm_valid), .bm_ready(bm_ready), .bm_data(bm_data),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
        .idx_last(idx_last), .done(done), .empty(empty),
`ifdef PSI_COUNT_EN
        .isect_count(isect_count),
`endif
        .dbg_state(dbg_state)
    );

    // Clock / cycle counter: cycle p spans from rising edge p to rising edge p+1.
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples at the falling edge, mid-cycle.
    int         acc_q[$];
    logic [3:0] got_q[$];
    logic       got_last_q[$];
    int         hs_q[$];
    int         done_q[$];
    logic       empty_q[$];
    logic [4:0] count_q[$];
    int         n_valid_total = 0;

    always @(negedge clk) begin
        if (bm_valid && bm_ready) acc_q.push_back(cyc);
        if (idx_valid) n_valid_total++;
        if (idx_valid && idx_ready) begin
            got_q.push_back(idx_data);
            got_last_q.push_back(idx_last);
            hs_q.push_back(cyc);
        end
        if (done) begin
            done_q.push_back(cyc);
            empty_q.push_back(empty);
`ifdef PSI_COUNT_EN
            count_q.push_back(isect_count);
`else
            count_q.push_back(5'd0);
`endif
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];
    int         exp_c[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a bitmap and return the cycle it was accepted in.
    task automatic send_bm(input logic [9:0] d, output int t);
        int nb;
        nb = acc_q.size();
        bm_data  = d;
        bm_valid = 1'b1;
        for (int k = 0; k < 100 && acc_q.size() == nb; k++) tick();
        bm_valid = 1'b0;
        t = 0;
        if (acc_q.size() == nb) begin
            n_checks++;
            $display("FAIL send_bm: bitmap %h never accepted", d);
        end else begin
            t = acc_q[nb];
        end
    endtask

    task automatic wait_done(input int nd, input string name);
        for (int k = 0; k < 200 && done_q.size() <= nd; k++) tick();
        if (done_q.size() <= nd) begin
            n_checks++;
            $display("FAIL %s_done_timeout: no done pulse", name);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 50 && !idx_valid; k++) tick();
        if (!idx_valid) begin
            n_checks++;
            $display("FAIL %s_valid_timeout: idx_valid never rose", name);
        end
    endtask

    // Compare the handshakes recorded since nh against exp_q/exp_c; last flag only on final entry.
    task automatic check_stream(input int nh, input string name);
        n_checks++;
        if (got_q.size() - nh !== exp_q.size()) begin
            $display("FAIL %s_count: got %0d indices, expected %0d", name, got_q.size() - nh, exp_q.size());
        end else begin
            n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[nh+i] !== exp_q[i] || hs_q[nh+i] !== exp_c[i] ||
                    got_last_q[nh+i] !== (i == exp_q.size() - 1))
                    $display("FAIL %s_idx%0d: got idx %0d at cyc %0d last %b, expected idx %0d at cyc %0d last %b",
                             name, i, got_q[nh+i], hs_q[nh+i], got_last_q[nh+i],
                             exp_q[i], exp_c[i], (i == exp_q.size() - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic check_done(input int nd, input int exp_cyc, input logic exp_empty,
                              input logic [4:0] exp_cnt, input string name);
        if (done_q.size() > nd) begin
            n_checks++;
            if (done_q[nd] !== exp_cyc || empty_q[nd] !== exp_empty)
                $display("FAIL %s_done: done at %0d empty %b, expected at %0d empty %b",
                         name, done_q[nd], empty_q[nd], exp_cyc, exp_empty);
            else n_pass++;
`ifdef PSI_COUNT_EN
            n_checks++;
            if (count_q[nd] !== exp_cnt)
                $display("FAIL %s_isect_count: got %0d expected %0d", name, count_q[nd], exp_cnt);
            else n_pass++;
`else
            if (exp_cnt > 5'd10) $display("FAIL %s_cnt_arg: bad expected count %0d", name, exp_cnt);
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bm_valid = 1'b0; bm_data = '0; idx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++;
        if ({bm_ready, idx_valid, idx_data, idx_last, done, empty, dbg_state} !== 11'b1_0_0000_0_0_0_00)
            $display("FAIL reset_outputs: rdy %b vld %b data %0d last %b done %b empty %b st %0d, expected rdy 1 others 0",
                     bm_ready, idx_valid, idx_data, idx_last, done, empty, dbg_state);
        else n_pass++;
`ifdef PSI_COUNT_EN
        n_checks++;
        if (isect_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", isect_count);
        else n_pass++;
`endif
    endtask

    task automatic test_sparse();
        int t, nh, nd;
        nh = hs_q.size(); nd = done_q.size();
        idx_ready = 1'b1;
        send_bm(10'b10_0000_0101, t);
        wait_done(nd, "sparse");
        exp_q = '{4'd0, 4'd2, 4'd9};
        exp_c = '{t + 2, t + 5, t + 13};
        check_stream(nh, "sparse");
        check_done(nd, t + 14, 1'b0, 5'd3, "sparse");
    endtask

    task automatic test_empty();
        int t, nh, nd, nv;
        nh = hs_q.size(); nd = done_q.size(); nv = n_valid_total;
        send_bm(10'h000, t);
        wait_done(nd, "empty");
        n_checks++;
        if (n_valid_total !== nv || hs_q.size() !== nh)
            $display("FAIL empty_no_valid: saw %0d valid cycles, expected 0", n_valid_total - nv);
        else n_pass++;
        check_done(nd, t + 11, 1'b1, 5'd0, "empty");
    endtask

    task automatic test_stall();
        int t, nh, nd, p;
        nh = hs_q.size(); nd = done_q.size();
        idx_ready = 1'b0;
        send_bm(10'h010, t);
        wait_valid("stall");
        p = cyc;
        n_checks++;
        if (p !== t + 6) $display("FAIL stall_latency: first valid at %0d expected %0d", p, t + 6);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (idx_valid !== 1'b1 || idx_data !== 4'd4 || idx_last !== 1'b1 || done !== 1'b0)
                $display("FAIL stall_hold%0d: vld %b data %0d last %b done %b, expected 1 4 1 0",
                         i, idx_valid, idx_data, idx_last, done);
            else n_pass++;
            if (i == 5) idx_ready = 1'b1;
            else tick();
        end
        wait_done(nd, "stall");
        exp_q = '{4'd4};
        exp_c = '{p + 5};
        check_stream(nh, "stall");
        check_done(nd, p + 6, 1'b0, 5'd1, "stall");
    endtask

    task automatic test_all_ones();
        int t, nh, nd;
        nh = hs_q.size(); nd = done_q.size();
        idx_ready = 1'b1;
        send_bm(10'h3FF, t);
        wait_done(nd, "ones");
        exp_q.delete(); exp_c.delete();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(4'(i));
            exp_c.push_back(t + 2 + 2 * i);
        end
        check_stream(nh, "ones");
        check_done(nd, t + 21, 1'b0, 5'd10, "ones");
    endtask

    // Second bitmap held valid through the first decode, including its done cycle.
    task automatic test_back_to_back();
        int t1, t2, nh, nd, na;
        nh = hs_q.size(); nd = done_q.size(); na = acc_q.size();
        idx_ready = 1'b1;
        send_bm(10'h300, t1);
        bm_data  = 10'h001;
        bm_valid = 1'b1;
        for (int k = 0; k < 100 && acc_q.size() < na + 2; k++) tick();
        bm_valid = 1'b0;
        t2 = (acc_q.size() >= na + 2) ? acc_q[na+1] : -1;
        n_checks++;
        if (t2 !== t1 + 14) $display("FAIL b2b_accept: second accept at %0d expected %0d", t2, t1 + 14);
        else n_pass++;
        wait_done(nd + 1, "b2b");
        exp_q = '{4'd8, 4'd9};
        exp_c = '{t1 + 10, t1 + 12};
        if (got_q.size() - nh == 3) begin
            n_checks++;
            if (got_q[nh+2] !== 4'd0 || hs_q[nh+2] !== t1 + 16 || got_last_q[nh+2] !== 1'b1)
                $display("FAIL b2b_second: got idx %0d at %0d last %b, expected 0 at %0d last 1",
                         got_q[nh+2], hs_q[nh+2], got_last_q[nh+2], t1 + 16);
            else n_pass++;
            void'(got_q.pop_back()); void'(hs_q.pop_back()); void'(got_last_q.pop_back());
        end
        check_stream(nh, "b2b");
        check_done(nd, t1 + 13, 1'b0, 5'd2, "b2b_first");
        check_done(nd + 1, t1 + 17, 1'b0, 5'd1, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int t, nh, nd;
        idx_ready = 1'b0;
        send_bm(10'h004, t);
        wait_valid("rstmid");
        n_checks++;
        if (idx_data !== 4'd2) $display("FAIL rstmid_pending: idx %0d expected 2", idx_data);
        else n_pass++;
        nh = hs_q.size(); nd = done_q.size();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bm_ready, idx_valid, idx_data, idx_last, done, empty} !== 9'b1_0_0000_0_0_0)
            $display("FAIL rstmid_outputs: rdy %b vld %b data %0d last %b done %b empty %b, expected rdy 1 others 0",
                     bm_ready, idx_valid, idx_data, idx_last, done, empty);
        else n_pass++;
`ifdef PSI_COUNT_EN
        n_checks++;
        if (isect_count !== 5'd0) $display("FAIL rstmid_count: got %0d expected 0", isect_count);
        else n_pass++;
`endif
        rst = 1'b0;
        idx_ready = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (done_q.size() !== nd || hs_q.size() !== nh)
            $display("FAIL rstmid_aborted: %0d done pulses, %0d transfers after reset, expected 0 0",
                     done_q.size() - nd, hs_q.size() - nh);
        else n_pass++;
        send_bm(10'h002, t);
        wait_done(nd, "rstmid");
        exp_q = '{4'd1};
        exp_c = '{t + 3};
        check_stream(nh, "rstmid");
        check_done(nd, t + 4, 1'b0, 5'd1, "rstmid");
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_empty();
        test_stall();
        test_all_ones();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
